dc_job_scheduler: RTL and testbench
===================================

// Module: dc_job_scheduler
// PURPOSE
//  Queues accelerator jobs (opcode, offset, filesize) from the host, then issues them one at a time
//  to dc_router_top on its instruction/offset/filesize inputs. Holds each job until acc_done,
//  returns instruction to idle (0) for a guard gap, then issues the next job. Sits between the
//  host/control interface and dc_router_top. Watchdog aborts hung jobs.
// PARAMETERS
//  QUEUE_DEPTH    4     job FIFO entries (power of 2, >=2)
//  GAP_CYCLES     4     min cycles instruction held at 0 between jobs (>=1)
//  TIMEOUT_CYCLES 4096  max cycles in RUN before abort
//  CNT_W          16    width of jobs_done counter
// PORTS
//  clk           in   1      clock, all logic on posedge
//  reset         in   1      asynchronous, active-low reset
//  job_valid     in   1      host job request
//  job_ready     out  1      job accepted on edge where job_valid && job_ready
//  job_opcode    in   2      01 FFT, 10 FIR, 11 IIR, 00 illegal
//  job_offset    in   32     RAM start address of job
//  job_filesize  in   32     job length
//  instruction   out  32     to dc_router_top; {30'b0, opcode} or 0 when idle
//  offset        out  32     to dc_router_top
//  filesize      out  32     to dc_router_top
//  acc_done      in   1      from dc_router_top; job complete
//  busy          out  1      1 in RUN or GAP, or queue non-empty
//  queue_level   out  $clog2(QUEUE_DEPTH)+1  current FIFO occupancy
//  jobs_done     out  CNT_W  completed-job counter, wraps
//  err_status    out  2      sticky: [0] timeout abort, [1] illegal opcode dropped
//  err_clear     in   1      clears err_status (set wins if same cycle)
// BEHAVIOUR
//  Reset (reset=0, async): FIFO empty, state IDLE, instruction/offset/filesize=0, jobs_done=0,
//   err_status=0, busy=0, queue_level=0, job_ready=0 while asserted; 1 from first edge after release.
//  job_ready = !fifo_full (registered occupancy); no bypass, no push when full.
//  Opcode 00 handshakes normally but is not enqueued; sets err_status[1].
//  Push and pop in the same cycle are both allowed; occupancy is unchanged.
//  FSM (all outputs registered):
//   IDLE: if FIFO non-empty, pop; load instruction/offset/filesize from head -> RUN.
//         Latency: job accepted at edge k into empty FIFO -> instruction valid after edge k+2.
//   RUN:  hold instruction/offset/filesize stable; watchdog counts cycles.
//         acc_done=1: jobs_done+1; instruction<=0 -> GAP.
//         Watchdog reaches TIMEOUT_CYCLES-1 with acc_done=0: set err_status[0]; instruction<=0;
//         jobs_done unchanged -> GAP. If acc_done and timeout occur in the same cycle, done wins.
//   GAP:  instruction=0; offset/filesize hold last values. Gap counter counts GAP_CYCLES.
//         Leave to IDLE only when count expired AND acc_done=0. If acc_done stays high,
//         remain in GAP indefinitely; no new issue.
//  acc_done seen in IDLE or GAP: ignored (no count).
//  Mid-operation reset: job aborted, queue flushed, all outputs return to reset values
//   asynchronously.
//  jobs_done wraps at 2^CNT_W-1 -> 0. queue_level is exact after every edge.
// STRUCTURE
//  Include file dc_router_defs.vh: OP_IDLE=2'b00, OP_FFT=2'b01, OP_FIR=2'b10, OP_IIR=2'b11;
//   FSM state encodings S_IDLE/S_RUN/S_GAP.
//  Sub-module dc_job_fifo: sync FIFO, width 66 {opcode,offset,filesize}, depth QUEUE_DEPTH,
//   push/pop/full/empty/level, async active-low reset. Top holds FSM, gap/watchdog counters
//   and error/count registers.
// TESTING
//  1. Single FFT job (01, offset 100, size 40) at edge k -> instruction=1, offset=100, filesize=40
//     after k+2; acc_done 10 cycles later -> instruction=0, jobs_done=1, >=4 idle cycles.
//  2. Push 5 jobs back-to-back (FFT, FIR, IIR, FFT, FIR) with acc_done stalled ->
//     job_ready=0 once level=4 with 1 in RUN; jobs issue in order 1,2,3,1,2, each separated
//     by >=GAP_CYCLES zeros.
//  3. Opcode 00 pushed -> not enqueued, queue_level unchanged, err_status=2'b10;
//     err_clear -> 2'b00.
//  4. TIMEOUT_CYCLES=16, no acc_done -> instruction=0 after 16 RUN cycles,
//     err_status[0]=1, jobs_done=0, next queued job issued.
//  5. acc_done held high 10 cycles after done -> scheduler stays in GAP until acc_done falls,
//     then issues next job.
//  6. reset low during RUN with 3 queued -> instruction=0, queue_level=0, busy=0
//     immediately; no issue after release until a new push.

Source files
------------

// File: rtl/dc_job_scheduler_pkg.sv
// dc_job_scheduler_pkg: opcodes, FSM states and the queued job record shared by the scheduler files
package dc_job_scheduler_pkg;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_FFT  = 2'b01;
    localparam logic [1:0] OP_FIR  = 2'b10;
    localparam logic [1:0] OP_IIR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_GAP  = 2'b10
    } state_t;

    typedef struct packed {
        logic [1:0]  opcode;
        logic [31:0] offset;
        logic [31:0] filesize;
    } job_t;

    localparam int JOB_W = $bits(job_t);

endpackage

// File: rtl/dc_job_fifo.sv
// dc_job_fifo: synchronous job FIFO with registered read data and exact occupancy
module dc_job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = r_level == LW'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_push ? r_wptr : r_wptr] <= i_wdata;
    end

    // pointers, occupancy and the popped head word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            o_rdata <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr  <= r_rptr + 1'b1;
                o_rdata <= r_mem[r_rptr];
            end
            r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

endmodule

// File: rtl/dc_job_scheduler.sv
// dc_job_scheduler: queues host accelerator jobs and issues them one at a time to dc_router_top
module dc_job_scheduler
    import dc_job_scheduler_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16,
    localparam int LW = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [1:0]       job_opcode,
    input  logic [31:0]      job_offset,
    input  logic [31:0]      job_filesize,
    output logic [31:0]      instruction,
    output logic [31:0]      offset,
    output logic [31:0]      filesize,
    input  logic             acc_done,
    output logic             busy,
    output logic [LW-1:0]    queue_level,
    output logic [CNT_W-1:0] jobs_done,
    output logic [1:0]       err_status,
    input  logic             err_clear
);

    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;

    state_t         r_state;
    state_t         w_next;
    logic           r_init;
    logic           r_issue;
    logic [WW-1:0]  r_wd;
    logic [GW-1:0]  r_gap;
    logic           w_accept;
    logic           w_push;
    logic           w_illegal;
    logic           w_pop;
    logic           w_load;
    logic           w_done;
    logic           w_timeout;
    logic           w_full;
    logic           w_empty;
    logic           w_gap_exp;
    job_t           w_head;

    assign job_ready = r_init && !w_full;
    assign w_accept  = job_valid && job_ready;
    assign w_push    = w_accept && job_opcode != OP_IDLE;
    assign w_illegal = w_accept && job_opcode == OP_IDLE;
    assign w_gap_exp = r_gap == GW'(GAP_CYCLES - 1);
    // r_issue covers the cycle between popping a job and loading it into RUN
    assign busy      = r_state != S_IDLE || r_issue || !w_empty;

    dc_job_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (JOB_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata ({job_opcode, job_offset, job_filesize}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (queue_level)
    );

    // next state: pop then load from IDLE, finish or abort in RUN, guard gap before next issue
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_load    = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop  = !r_issue && !w_empty;
                w_load = r_issue;
                w_next = r_issue ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                w_done    = acc_done;
                w_timeout = !acc_done && r_wd == WW'(TIMEOUT_CYCLES - 1);
                w_next    = (w_done || w_timeout) ? S_GAP : S_RUN;
            end
            S_GAP:   w_next = (w_gap_exp && !acc_done) ? S_IDLE : S_GAP;
            default: w_next = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // watchdog and gap counters, issue handshake and post-reset ready enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_init  <= 1'b0;
            r_issue <= 1'b0;
            r_wd    <= '0;
            r_gap   <= '0;
        end else begin
            r_init  <= 1'b1;
            r_issue <= w_pop;
            r_wd    <= (r_state == S_RUN) ? r_wd + 1'b1 : '0;
            r_gap   <= (r_state != S_GAP) ? '0 : (w_gap_exp ? r_gap : r_gap + 1'b1);
        end
    end

    // router-facing job registers; offset/filesize keep the last job through the gap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= '0;
            offset      <= '0;
            filesize    <= '0;
        end else if (w_load) begin
            instruction <= {30'b0, w_head.opcode};
            offset      <= w_head.offset;
            filesize    <= w_head.filesize;
        end else if (w_done || w_timeout) begin
            instruction <= '0;
        end
    end

    // completion counter and sticky error flags; a new error beats a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            jobs_done  <= '0;
            err_status <= '0;
        end else begin
            jobs_done  <= jobs_done + CNT_W'(w_done);
            err_status <= (err_clear ? 2'b00 : err_status) | {w_illegal, w_timeout};
        end
    end

endmodule

// File: tb/tb_dc_job_scheduler.sv
// tb_dc_job_scheduler: directed jobs with a scoreboard that checks every issue against the push order
module tb_dc_job_scheduler;

    localparam int QD  = 4;
    localparam int GAP = 4;
    localparam int TO  = 16;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [1:0]    job_opcode = '0;
    logic [31:0]   job_offset = '0;
    logic [31:0]   job_filesize = '0;
    logic [31:0]   instruction;
    logic [31:0]   offset;
    logic [31:0]   filesize;
    logic          acc_done = 1'b0;
    logic          busy;
    logic [2:0]    queue_level;
    logic [CW-1:0] jobs_done;
    logic [1:0]    err_status;
    logic          err_clear = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          exp_done = 0;
    logic [65:0] exp_q [$];
    logic [65:0] mon_e;
    logic [31:0] mon_prev = '0;
    int          mon_zeros = 1000;

    always #5 clk = ~clk;

    dc_job_scheduler #(
        .QUEUE_DEPTH    (QD),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_opcode   (job_opcode),
        .job_offset   (job_offset),
        .job_filesize (job_filesize),
        .instruction  (instruction),
        .offset       (offset),
        .filesize     (filesize),
        .acc_done     (acc_done),
        .busy         (busy),
        .queue_level  (queue_level),
        .jobs_done    (jobs_done),
        .err_status   (err_status),
        .err_clear    (err_clear)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // each issue (instruction leaving 0) must match the oldest queued expectation and follow a full gap
    always @(negedge clk) begin
        if (!reset) begin
            mon_prev  = '0;
            mon_zeros = 1000;
        end else begin
            if (instruction != 0 && mon_prev == 0) begin
                chk("issue_gap", 32'(mon_zeros >= GAP), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", instruction, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("issue_instr", instruction, {30'b0, mon_e[65:64]});
                    chk("issue_offset", offset, mon_e[63:32]);
                    chk("issue_size", filesize, mon_e[31:0]);
                end
            end else if (instruction != 0 && instruction != mon_prev) begin
                chk("instr_stable", instruction, mon_prev);
            end
            mon_zeros = (instruction == 0) ? mon_zeros + 1 : 0;
            mon_prev  = instruction;
        end
    end

    task automatic push_job(input logic [1:0] op, input logic [31:0] off, input logic [31:0] sz);
        int n = 0;
        job_valid = 1'b1;
        job_opcode = op;
        job_offset = off;
        job_filesize = sz;
        while (!job_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 100) chk("push_ready_timeout", 32'(job_ready), 32'd1);
        @(posedge clk);
        if (op != 2'b00 && n < 100) exp_q.push_back({op, off, sz});
        #1 job_valid = 1'b0;
    endtask

    task automatic serve(input int dly, input int hold);
        int n = 0;
        while (instruction == 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("serve_issue_timeout", 32'(n < 100), 32'd1);
        repeat (dly) @(posedge clk);
        #1 acc_done = 1'b1;
        repeat (hold) @(posedge clk);
        #1 acc_done = 1'b0;
        exp_done++;
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        #2 reset = 1'b0;
        #10;
        chk("rst_ready", 32'(job_ready), 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_level", 32'(queue_level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(jobs_done), 32'd0);
        chk("rst_err", 32'(err_status), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", 32'(job_ready), 32'd1);

        // single FFT job: exact two-edge issue latency, done, gap, idle
        push_job(2'b01, 32'd100, 32'd40);
        chk("t1_level_k", 32'(queue_level), 32'd1);
        chk("t1_instr_k", instruction, 32'd0);
        @(posedge clk);
        #1;
        chk("t1_instr_k1", instruction, 32'd0);
        chk("t1_level_k1", 32'(queue_level), 32'd0);
        @(posedge clk);
        #1;
        chk("t1_instr_k2", instruction, 32'd1);
        chk("t1_offset_k2", offset, 32'd100);
        chk("t1_size_k2", filesize, 32'd40);
        chk("t1_busy_run", 32'(busy), 32'd1);
        repeat (10) @(posedge clk);
        #1 acc_done = 1'b1;
        @(posedge clk);
        #1 acc_done = 1'b0;
        exp_done++;
        chk("t1_instr_done", instruction, 32'd0);
        chk("t1_jobs_done", 32'(jobs_done), 32'(exp_done % 8));
        chk("t1_offset_hold", offset, 32'd100);
        repeat (12) @(posedge clk);
        #1;
        chk("t1_busy_idle", 32'(busy), 32'd0);

        // five back-to-back jobs fill the queue behind the running one
        push_job(2'b01, 32'd200, 32'd10);
        push_job(2'b10, 32'd201, 32'd11);
        push_job(2'b11, 32'd202, 32'd12);
        push_job(2'b01, 32'd203, 32'd13);
        push_job(2'b10, 32'd204, 32'd14);
        chk("t2_level_full", 32'(queue_level), 32'd4);
        chk("t2_ready_full", 32'(job_ready), 32'd0);
        chk("t2_running", instruction, 32'd1);
        for (int i = 0; i < 5; i++) serve(3, 1);
        chk("t2_jobs_done", 32'(jobs_done), 32'(exp_done % 8));
        settle();

        // illegal opcode: handshaken but dropped; a set beats a same-cycle clear
        push_job(2'b00, 32'd5, 32'd5);
        chk("t3_level", 32'(queue_level), 32'd0);
        chk("t3_err_set", 32'(err_status), 32'd2);
        err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
        chk("t3_err_clear", 32'(err_status), 32'd0);
        err_clear = 1'b1;
        push_job(2'b00, 32'd6, 32'd6);
        err_clear = 1'b0;
        chk("t3_set_wins", 32'(err_status), 32'd2);
        err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
        chk("t3_err_clear2", 32'(err_status), 32'd0);
        settle();

        // watchdog abort after exactly TO cycles, then the next job still issues
        push_job(2'b01, 32'd300, 32'd50);
        push_job(2'b11, 32'd400, 32'd60);
        n = 0;
        while (instruction == 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        n = 0;
        while (instruction != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t4_run_cycles", 32'(n), 32'(TO));
        chk("t4_err_timeout", 32'(err_status), 32'd1);
        chk("t4_jobs_unchanged", 32'(jobs_done), 32'(exp_done % 8));
        serve(3, 1);
        chk("t4_next_done", 32'(jobs_done), 32'(exp_done % 8));
        err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
        settle();

        // acc_done on the watchdog's last cycle counts as done; counter wraps here
        push_job(2'b11, 32'd700, 32'd90);
        serve(15, 1);
        chk("t4_done_wins_err", 32'(err_status), 32'd0);
        chk("t4_done_wins_wrap", 32'(jobs_done), 32'(exp_done % 8));
        settle();

        // acc_done held high keeps the scheduler parked in the gap
        push_job(2'b10, 32'd500, 32'd70);
        push_job(2'b01, 32'd600, 32'd80);
        serve(3, 10);
        chk("t5_held_instr", instruction, 32'd0);
        chk("t5_held_level", 32'(queue_level), 32'd1);
        chk("t5_held_busy", 32'(busy), 32'd1);
        chk("t5_held_count", 32'(jobs_done), 32'(exp_done % 8));
        serve(3, 1);
        chk("t5_next_done", 32'(jobs_done), 32'(exp_done % 8));
        settle();

        // reset in RUN with three queued flushes everything at once
        push_job(2'b01, 32'd800, 32'd1);
        push_job(2'b10, 32'd801, 32'd2);
        push_job(2'b11, 32'd802, 32'd3);
        push_job(2'b01, 32'd803, 32'd4);
        chk("t6_level_pre", 32'(queue_level), 32'd3);
        chk("t6_run_pre", instruction, 32'd1);
        #2 reset = 1'b0;
        exp_q.delete();
        exp_done = 0;
        #1;
        chk("t6_instr", instruction, 32'd0);
        chk("t6_level", 32'(queue_level), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ready", 32'(job_ready), 32'd0);
        chk("t6_done", 32'(jobs_done), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_no_issue", instruction, 32'd0);
        chk("t6_level_after", 32'(queue_level), 32'd0);
        push_job(2'b10, 32'd900, 32'd5);
        serve(3, 1);
        chk("t6_new_done", 32'(jobs_done), 32'(exp_done % 8));
        settle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
